// File: rtl/load_if.sv
// load_if: request, memory-read and register-write signals of load_unit
interface load_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_funct3;
   logic [4:0]  req_rd;
   logic        mem_rd_valid;
   logic        mem_rd_ready;
   logic [31:0] mem_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        wr_enable;
   logic [4:0]  wr_address;
   logic [31:0] wr_data;
   logic [2:0]  write_pattern;
   logic        busy;
   logic        load_err;
   modport master (
      input  req_valid, req_addr, req_funct3, req_rd, mem_rd_ready, mem_resp_valid, mem_resp_data,
      output req_ready, mem_rd_valid, mem_addr, wr_enable, wr_address, wr_data, write_pattern, busy, load_err
   );
   modport slave (
      output req_valid, req_addr, req_funct3, req_rd, mem_rd_ready, mem_resp_valid, mem_resp_data,
      input  req_ready, mem_rd_valid, mem_addr, wr_enable, wr_address, wr_data, write_pattern, busy, load_err
   );
endinterface

// File: rtl/load_unit.sv
// load_unit: RV32I load FSM (IDLE/REQ/WAIT/WB); define MISALIGN_CHECK_EN to reject misaligned LH/LHU/LW
module load_unit (
   input  logic   clk,
   input  logic   reset_n,
   load_if.master bus
);
   localparam logic [2:0] REG_WRITE_BYTE_SIGNED   = 3'd1;
   localparam logic [2:0] REG_WRITE_HALF_SIGNED   = 3'd2;
   localparam logic [2:0] REG_WRITE_WORD          = 3'd3;
   localparam logic [2:0] REG_WRITE_BYTE_UNSIGNED = 3'd4;
   localparam logic [2:0] REG_WRITE_HALF_UNSIGNED = 3'd5;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;
   state_t      state, state_nx;
   logic [31:0] addr, data, lane;
   logic [2:0]  funct3, pattern;
   logic [4:0]  rd;
   logic        legal, misaligned;
`ifdef MISALIGN_CHECK_EN
   assign misaligned = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                       (bus.req_funct3 == 3'b010 && bus.req_addr[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif
   assign legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101} && !misaligned;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = (bus.req_valid && legal) ? REQ : IDLE;
         REQ:     state_nx = bus.mem_rd_ready ? WAIT : REQ;
         WAIT:    state_nx = bus.mem_resp_valid ? WB : WAIT;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         addr   <= '0;
         funct3 <= '0;
         rd     <= '0;
         data   <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && bus.req_valid && legal) begin
            addr   <= bus.req_addr;
            funct3 <= bus.req_funct3;
            rd     <= bus.req_rd;
         end
         if (state == WAIT && bus.mem_resp_valid) data <= bus.mem_resp_data;
      end
   end
   // only legal funct3 values are ever captured, so the final arm is LHU
   assign pattern = funct3 == 3'b000 ? REG_WRITE_BYTE_SIGNED :
                    funct3 == 3'b001 ? REG_WRITE_HALF_SIGNED :
                    funct3 == 3'b010 ? REG_WRITE_WORD :
                    funct3 == 3'b100 ? REG_WRITE_BYTE_UNSIGNED : REG_WRITE_HALF_UNSIGNED;
   assign lane = funct3[1] ? data :
                 funct3[0] ? data >> {addr[1], 4'b0000} : data >> {addr[1:0], 3'b000};
   assign bus.req_ready     = reset_n && state == IDLE;
   assign bus.busy          = state != IDLE;
   assign bus.load_err      = state == IDLE && bus.req_valid && !legal;
   assign bus.mem_rd_valid  = state == REQ;
   assign bus.mem_addr      = {addr[31:2], 2'b00};
   assign bus.wr_enable     = state == WB && rd != 5'd0;
   assign bus.wr_address    = bus.wr_enable ? rd : 5'd0;
   assign bus.wr_data       = bus.wr_enable ? lane : 32'd0;
   assign bus.write_pattern = bus.wr_enable ? pattern : 3'd0;
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed table, hand sequences and randomized loads checked against a reference model
module tb_load_unit;
   localparam logic [2:0] P_BS = 3'd1, P_HS = 3'd2, P_W = 3'd3, P_BU = 3'd4, P_HU = 3'd5;
`ifdef MISALIGN_CHECK_EN
   localparam logic MIS = 1'b1;
`else
   localparam logic MIS = 1'b0;
`endif
   typedef struct {
      logic [31:0] a;
      logic [2:0]  f;
      logic [4:0]  rd;
      logic [31:0] d;
      logic        err;
      logic [31:0] ma;
      logic        we;
      logic [31:0] wd;
      logic [2:0]  pat;
   } vec_t;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n = 0;
   int   fails = 0;
   vec_t tbl[$];
   load_if bus();
   load_unit dut (.clk(clk), .reset_n(reset_n), .bus(bus.master));
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, " busy"}, bus.busy, 0);
      chk({tag, " mem_rd_valid"}, bus.mem_rd_valid, 0);
      chk({tag, " mem_addr"}, bus.mem_addr, 0);
      chk({tag, " wr_enable"}, bus.wr_enable, 0);
      chk({tag, " wr_address"}, bus.wr_address, 0);
      chk({tag, " wr_data"}, bus.wr_data, 0);
      chk({tag, " write_pattern"}, bus.write_pattern, 0);
      chk({tag, " load_err"}, bus.load_err, 0);
   endtask

   function automatic logic m_err(input logic [31:0] a, input logic [2:0] f);
      if (!(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
      if (MIS && (f == 3'd1 || f == 3'd5) && a % 2 != 0) return 1'b1;
      if (MIS && f == 3'd2 && a % 4 != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_wd(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
      int byte_off = int'(a % 4);
      if (f == 3'd0 || f == 3'd4) return d >> (8 * byte_off);
      if (f == 3'd1 || f == 3'd5) return d >> (16 * (byte_off / 2));
      return d;
   endfunction

   function automatic logic [2:0] m_pat(input logic [2:0] f);
      case (f)
         3'd0: return P_BS;
         3'd1: return P_HS;
         3'd2: return P_W;
         3'd4: return P_BU;
         default: return P_HU;
      endcase
   endfunction

   task automatic run_load(input logic [31:0] a, input logic [2:0] f, input logic [4:0] rd,
                           input logic [31:0] d, input int stall, input int rdel, input logic junk,
                           input logic e_err, input logic [31:0] e_ma, input logic e_we,
                           input logic [31:0] e_wd, input logic [2:0] e_pat);
      @(negedge clk);
      chk("idle req_ready", bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_addr = a;
      bus.req_funct3 = f;
      bus.req_rd = rd;
      #1 chk("accept load_err", bus.load_err, e_err);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_addr = $urandom;
      bus.req_funct3 = 3'd3;
      #1 chk("post load_err", bus.load_err, 0);
      if (e_err) begin
         chk("reject busy", bus.busy, 0);
         chk("reject mem_rd_valid", bus.mem_rd_valid, 0);
         return;
      end
      for (int k = 0; k <= stall; k++) begin
         if (k > 0) @(negedge clk);
         bus.mem_rd_ready = (k == stall);
         bus.mem_resp_valid = junk;
         bus.mem_resp_data = ~d;
         #1 chk("req mem_rd_valid", bus.mem_rd_valid, 1);
         chk("req mem_addr", bus.mem_addr, e_ma);
         chk("req busy", bus.busy, 1);
         chk("req req_ready", bus.req_ready, 0);
      end
      for (int k = 0; k <= rdel; k++) begin
         @(negedge clk);
         bus.mem_rd_ready = 1'b0;
         bus.mem_resp_valid = (k == rdel);
         bus.mem_resp_data = (k == rdel) ? d : 32'($urandom);
         #1 chk("wait mem_rd_valid", bus.mem_rd_valid, 0);
         chk("wait wr_enable", bus.wr_enable, 0);
      end
      @(negedge clk);
      bus.mem_resp_valid = junk;
      bus.mem_resp_data = ~d;
      #1 chk("wb wr_enable", bus.wr_enable, e_we);
      chk("wb wr_address", bus.wr_address, e_we ? 32'(rd) : 0);
      chk("wb wr_data", bus.wr_data, e_we ? e_wd : 0);
      chk("wb write_pattern", bus.write_pattern, e_we ? 32'(e_pat) : 0);
      chk("wb busy", bus.busy, 1);
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      #1 chk("done wr_enable", bus.wr_enable, 0);
      chk("done busy", bus.busy, 0);
      chk("done req_ready", bus.req_ready, 1);
   endtask

   initial begin
      bus.req_valid = 0;
      bus.req_addr = 0;
      bus.req_funct3 = 0;
      bus.req_rd = 0;
      bus.mem_rd_ready = 0;
      bus.mem_resp_valid = 0;
      bus.mem_resp_data = 0;
      #12;
      chk_quiet("reset");
      chk("reset req_ready", bus.req_ready, 0);
      @(negedge clk);
      reset_n = 1'b1;
      #1 chk("release req_ready", bus.req_ready, 1);

      tbl.push_back('{32'h100, 3'd2, 5'd5, 32'hABCDEFAB, 0, 32'h100, 1, 32'hABCDEFAB, P_W});
      tbl.push_back('{32'h103, 3'd4, 5'd15, 32'hFACDEF12, 0, 32'h100, 1, 32'h000000FA, P_BU});
      tbl.push_back('{32'h202, 3'd1, 5'd0, 32'h80011234, 0, 32'h200, 0, 32'h0, 3'd0});
      tbl.push_back('{32'h100, 3'd3, 5'd4, 32'h0, 1, 32'h0, 0, 32'h0, 3'd0});
      tbl.push_back('{32'h100, 3'd6, 5'd4, 32'h0, 1, 32'h0, 0, 32'h0, 3'd0});
      tbl.push_back('{32'h100, 3'd7, 5'd4, 32'h0, 1, 32'h0, 0, 32'h0, 3'd0});
      tbl.push_back('{32'h101, 3'd2, 5'd7, 32'h11223344, MIS, 32'h100, !MIS, 32'h11223344, P_W});
      tbl.push_back('{32'h001, 3'd0, 5'd1, 32'h12345678, 0, 32'h0, 1, 32'h00123456, P_BS});
      tbl.push_back('{32'h002, 3'd5, 5'd31, 32'hCAFEBABE, 0, 32'h0, 1, 32'h0000CAFE, P_HU});
      tbl.push_back('{32'h003, 3'd1, 5'd2, 32'hAABBCCDD, MIS, 32'h0, !MIS, 32'h0000AABB, P_HS});
      tbl.push_back('{32'hFFFFFFFC, 3'd0, 5'd3, 32'h87654321, 0, 32'hFFFFFFFC, 1, 32'h87654321, P_BS});
      foreach (tbl[i])
         run_load(tbl[i].a, tbl[i].f, tbl[i].rd, tbl[i].d, 0, 0, 1'b0,
                  tbl[i].err, tbl[i].ma, tbl[i].we, tbl[i].wd, tbl[i].pat);

      // stalled handshake with stray responses in REQ and WB that must be ignored
      run_load(32'h48, 3'd2, 5'd9, 32'h0BADF00D, 4, 2, 1'b1, 0, 32'h48, 1, 32'h0BADF00D, P_W);

      // reset while waiting for the response; the late response must not write
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr = 32'h40;
      bus.req_funct3 = 3'd2;
      bus.req_rd = 5'd9;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.mem_rd_ready = 1'b1;
      @(negedge clk);
      bus.mem_rd_ready = 1'b0;
      #1 chk("rst-wait busy", bus.busy, 1);
      chk("rst-wait mem_rd_valid", bus.mem_rd_valid, 0);
      reset_n = 1'b0;
      #1 chk_quiet("rst-wait");
      chk("rst-wait req_ready", bus.req_ready, 0);
      @(negedge clk);
      reset_n = 1'b1;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data = 32'h55AA55AA;
      #1 chk("rst-late req_ready", bus.req_ready, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1 chk("rst-late wr_enable", bus.wr_enable, 0);
         chk("rst-late busy", bus.busy, 0);
      end
      bus.mem_resp_valid = 1'b0;

      for (int i = 0; i < 60; i++) begin
         logic [31:0] a, d;
         logic [2:0]  f;
         logic [4:0]  rd;
         a = $urandom;
         d = $urandom;
         f = 3'($urandom_range(0, 7));
         rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
         run_load(a, f, rd, d, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                  m_err(a, f), {a[31:2], 2'b00}, rd != 0, m_wd(a, f, d), m_pat(f));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n, fails);
      $finish;
   end
endmodule
